fir_mac_sequencer: RTL
======================

Name: fir_mac_sequencer

Overview:
Initiator side of the FIR datapath ALU interface. It accepts input samples over a valid/ready handshake and keeps a TAPS-deep sample delay line and a TAPS-entry coefficient bank. For each sample it issues one multiply per tap to the 2-cycle ALU, accumulates the returned products locally, and presents each filter output over a valid/ready handshake.

Parameters:
TAPS, 8, number of filter taps (>=2)
DW, 16, sample/coefficient width; fixed by the ALU operand width
AW, 32, accumulator/output width; fixed by the ALU result width
CAW, $clog2(TAPS), coefficient address width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
coef_we  in  1  coefficient write strobe
coef_addr  in  CAW  coefficient index
coef_wdata  in  DW  coefficient value (unsigned)
in_valid  in  1  sample valid
in_ready  out  1  sample ready
in_data  in  DW  sample (unsigned)
out_valid  out  1  filter output valid
out_ready  in  1  downstream ready
out_data  out  AW  filter output
busy  out  1  high in every state except IDLE
alu_a  out  DW  ALU operand a (sample)
alu_b  out  DW  ALU operand b (coefficient)
alu_op_sel  out  2  ALU operation select
alu_result  in  AW  ALU result

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, alu_a=0, alu_b=0, alu_op_sel=OP_ADD. Delay line, coefficient bank, accumulator and tap counter are 0. State is IDLE.
- Reset mid-operation aborts the current computation immediately. Any pending output is discarded, and the sequencer returns to the reset values above.
- ALU timing contract: operands driven in cycle c; op_sel sampled in cycle c+1; product visible on alu_result in cycle c+2. The sequencer captures it at the edge ending cycle c+2.
- Tap indexing: x[0] is the newest sample. y = sum over k=0..TAPS-1 of coef[k]*x[k].
- Arithmetic: all values are unsigned. Each product is 32 bits. Accumulation is modulo 2^AW, with wrap-around and no saturation.
- States: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, the delay line shifts (x[k]<=x[k-1], x[0]<=in_data), the accumulator clears, the tap counter goes to 0, and the state moves to ISSUE.
- ISSUE:
  - Lasts exactly TAPS cycles.
  - In cycle k: alu_a=x[k], alu_b=coef[k], alu_op_sel=OP_MUL; the tap counter increments.
  - After tap TAPS-1, the state moves to DRAIN.
- DRAIN:
  - Lasts exactly 2 cycles, with alu_op_sel held at OP_MUL and operands held at 0.
  - A 2-bit valid shift pipe tracks in-flight products. acc<=acc+alu_result on every cycle where the pipe output is 1.
  - Then the state moves to OUTPUT, and out_data is loaded with the final acc.
- OUTPUT:
  - out_valid=1; out_data is held stable while out_ready=0.
  - On out_valid&&out_ready, out_valid falls on the next edge and the state moves to IDLE.
  - in_ready does not rise in the same cycle as the output handshake; no bypass.
- Latency: input handshake in cycle 0 gives out_valid high from cycle TAPS+3. Throughput is one sample per TAPS+4 cycles with out_ready tied high.
- alu_op_sel=OP_ADD in IDLE and OUTPUT. ALU results arriving outside the tracked pipe slots are ignored.
- Input side: in_ready=0 in ISSUE/DRAIN/OUTPUT, and in_valid is ignored there; the upstream holds the sample.
- Coefficient writes:
  - Accepted only in IDLE.
  - coef_we while busy=1 is ignored (dropped, not queued).
  - In the same IDLE cycle, a coefficient write and a sample handshake both take effect; the new coefficient is used for that sample.
- coef_addr >= TAPS (non-power-of-2 TAPS): write ignored.

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE/ISSUE/DRAIN/OUTPUT)
  - OP_ADD=2'b00, OP_MUL=2'b01
  - ALU_LATENCY=2
  - DW=16, AW=32 constants
- One natural sub-module: fir_tap_store. It holds the coefficient bank and the delay line, with a write port, a shift port and a combinational tap-indexed read. The FSM, issue counter, valid pipe and accumulator stay in fir_mac_sequencer.

Test Plan:
- Reset: assert rst mid-ISSUE -> in_ready=1, out_valid=0, out_data=0, busy=0, alu_op_sel=00 asynchronously. The next sample produces output from zeroed history.
- Impulse: coef[k]=k+1 (k=0..7), samples 1,0,0,0,0,0,0,0,0 with out_ready=1 -> outputs 1,2,3,4,5,6,7,8,0. out_valid first rises 11 cycles after the first handshake.
- Wrap-around: all coef=0xFFFF and eight samples of 0xFFFF -> eighth output is 0xFFF00008 (8*0xFFFE0001 mod 2^32).
- Backpressure: out_ready=0 for 5 cycles in OUTPUT -> out_data stable, in_ready=0, and a held in_valid is not accepted until the cycle after the output handshake.
- Coef write while busy: write coef[0]=0x0005 during ISSUE -> ignored, coef[0] unchanged. The same write issued in IDLE is used by the next sample.
- ALU protocol check (bound with the real ALU): alu_op_sel==01 one cycle after every issue cycle, and exactly TAPS products are accumulated per sample.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC sequencer and its ALU interface.
package fir_pkg;

  localparam int DW          = 16;
  localparam int AW          = 32;
  localparam int ALU_LATENCY = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Wrap-around accumulate; products arrive already AW wide from the ALU.
  function automatic logic [AW-1:0] mac_acc(input logic [AW-1:0] acc,
                                            input logic [AW-1:0] prod);
    return acc + prod;
  endfunction

endpackage

// File: rtl/fir_tap_store.sv
// Coefficient bank plus sample delay line; x[0] is the newest sample.
module fir_tap_store #(
  parameter int TAPS = 8,
  parameter int DW   = 16,
  parameter int CAW  = $clog2(TAPS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           coef_we,
  input  logic [CAW-1:0] coef_addr,
  input  logic [DW-1:0]  coef_wdata,
  input  logic           shift,
  input  logic [DW-1:0]  shift_data,
  input  logic [CAW-1:0] rd_idx,
  output logic [DW-1:0]  rd_x,
  output logic [DW-1:0]  rd_coef
);

  logic [TAPS-1:0][DW-1:0] coef_q;
  logic [TAPS-1:0][DW-1:0] x_q;
  logic                    addr_ok;

  // Out-of-range addresses only exist for non-power-of-2 TAPS.
  assign addr_ok = 32'(coef_addr) < TAPS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q <= '0;
    end else if (coef_we && addr_ok) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
    end else if (shift) begin
      x_q <= {x_q[TAPS-2:0], shift_data};
    end
  end

  assign rd_x    = x_q[rd_idx];
  assign rd_coef = coef_q[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one multiply per tap through the 2-cycle ALU and accumulates locally.
module fir_mac_sequencer #(
  parameter int TAPS = 8,
  parameter int DW   = fir_pkg::DW,
  parameter int AW   = fir_pkg::AW,
  parameter int CAW  = $clog2(TAPS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           coef_we,
  input  logic [CAW-1:0] coef_addr,
  input  logic [DW-1:0]  coef_wdata,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_data,
  output logic           busy,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [1:0]     alu_op_sel,
  input  logic [AW-1:0]  alu_result
);

  import fir_pkg::*;

  state_t                 state, state_nx;
  logic [CAW-1:0]         cnt;
  logic [1:0]             dcnt;
  logic [ALU_LATENCY-1:0] vld_pipe;
  logic [AW-1:0]          acc, acc_nx;
  logic [DW-1:0]          tap_x, tap_c;
  logic                   in_fire, issue, last_tap, last_drain;

  assign in_fire    = in_valid && in_ready;
  assign issue      = (state == ISSUE);
  assign last_tap   = (cnt == CAW'(TAPS-1));
  assign last_drain = (dcnt == 2'(ALU_LATENCY-1));

  fir_tap_store #(.TAPS(TAPS), .DW(DW), .CAW(CAW)) u_store (
    .clk        (clk),
    .rst        (rst),
    .coef_we    (coef_we && (state == IDLE)),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .shift      (in_fire),
    .shift_data (in_data),
    .rd_idx     (cnt),
    .rd_x       (tap_x),
    .rd_coef    (tap_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_fire)    state_nx = ISSUE;
      ISSUE:   if (last_tap)   state_nx = DRAIN;
      DRAIN:   if (last_drain) state_nx = OUTPUT;
      OUTPUT:  if (out_ready)  state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op_sel = OP_ADD;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ISSUE: begin
        alu_a      = tap_x;
        alu_b      = tap_c;
        alu_op_sel = OP_MUL;
      end
      // op_sel is sampled one cycle after the operands, so MUL is held here.
      DRAIN:   alu_op_sel = OP_MUL;
      OUTPUT:  out_valid  = 1'b1;
      default: ;
    endcase
  end

  // Only results lined up with an issue slot are accumulated.
  assign acc_nx = vld_pipe[ALU_LATENCY-1] ? mac_acc(acc, alu_result) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      acc      <= '0;
      cnt      <= '0;
      dcnt     <= '0;
      out_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ALU_LATENCY-2:0], issue};
      acc      <= in_fire ? '0 : acc_nx;
      if (in_fire)    cnt <= '0;
      else if (issue) cnt <= cnt + 1'b1;
      dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      // Final product lands in the last drain cycle; fold it in on the way out.
      if (state == DRAIN && last_drain) out_data <= acc_nx;
    end
  end

endmodule
